// File: rtl/map_writer.sv
// Sole writer of the map RAM: fills the map with flat terrain after reset or on
// request, then commits single-block place/break edits from the game-logic port.
module map_writer #(
  parameter int unsigned XB            = 5,
  parameter int unsigned ZB            = 5,
  parameter int unsigned YB            = 5,
  parameter int unsigned IDW           = 5,
  parameter int unsigned GROUND_Y      = 4,
  parameter int unsigned STONE_ID      = 1,
  parameter int unsigned DIRT_ID       = 2,
  parameter int unsigned GRASS_ID      = 3,
  parameter bit          PROTECT_FLOOR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regen,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [XB-1:0]         cmd_x,
  input  logic [YB-1:0]         cmd_y,
  input  logic [ZB-1:0]         cmd_z,
  input  logic [IDW-1:0]        cmd_id,
  output logic [XB+ZB+YB-1:0]   write_addr,
  output logic [IDW-1:0]        write_data,
  output logic                  write_en,
  output logic                  init_done,
  output logic                  busy,
  output logic                  map_changed,
  output logic                  cmd_rejected
);

  localparam int unsigned AW = XB + ZB + YB;

  typedef enum logic [1:0] {
    ST_SWEEP,
    ST_IDLE,
    ST_WRITE
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           wen_q, wen_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic [IDW-1:0] wdata_q, wdata_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           changed_q, changed_d;
  logic           rejected_q, rejected_d;
  logic           sweep_last;

  // Flat world: stone up to the dirt layer, one dirt layer, grass surface, air above.
  function automatic logic [IDW-1:0] terrain(input logic [YB-1:0] y);
    int unsigned yi;
    yi = int'(y);
    if (yi + 1 < GROUND_Y)       return IDW'(STONE_ID);
    else if (yi + 1 == GROUND_Y) return IDW'(DIRT_ID);
    else if (yi == GROUND_Y)     return IDW'(GRASS_ID);
    else                         return '0;
  endfunction

  // The visible cycle is the final sweep write once the top address is on the bus.
  assign sweep_last = wen_q && (waddr_q == '1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    done_d     = done_q;
    busy_d     = 1'b1;
    changed_d  = 1'b0;
    rejected_d = 1'b0;

    unique case (state_q)
      ST_SWEEP: begin
        if (sweep_last) begin
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          changed_d = 1'b1;
        end else begin
          wen_d   = 1'b1;
          waddr_d = cnt_q;
          wdata_d = terrain(cnt_q[AW-1 -: YB]);
          cnt_d   = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (regen) begin
          // Regeneration wins over a simultaneous edit, which stays pending.
          state_d = ST_SWEEP;
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end else if (cmd_valid) begin
          state_d = ST_WRITE;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          waddr_d = {cmd_y, cmd_z, cmd_x};
          wdata_d = cmd_id;
          if (PROTECT_FLOOR && (cmd_y == '0)) begin
            rejected_d = 1'b1;
          end else begin
            wen_d     = 1'b1;
            changed_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SWEEP;
      cnt_q      <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      changed_q  <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      changed_q  <= changed_d;
      rejected_q <= rejected_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign write_en     = wen_q;
  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;
  assign init_done    = done_q;
  assign busy         = busy_q;
  assign map_changed  = changed_q;
  assign cmd_rejected = rejected_q;

endmodule

// File: tb/tb_map_writer.sv
// Directed bench for map_writer: terrain sweeps, edits, floor protection,
// regen priority, mid-sweep reset and back-to-back edits.
module tb_map_writer;

  logic        clk;
  logic        rst_n;
  logic        regen;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_x;
  logic [4:0]  cmd_y;
  logic [4:0]  cmd_z;
  logic [4:0]  cmd_id;
  logic [14:0] write_addr;
  logic [4:0]  write_data;
  logic        write_en;
  logic        init_done;
  logic        busy;
  logic        map_changed;
  logic        cmd_rejected;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  map_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .regen        (regen),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_z        (cmd_z),
    .cmd_id       (cmd_id),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_en     (write_en),
    .init_done    (init_done),
    .busy         (busy),
    .map_changed  (map_changed),
    .cmd_rejected (cmd_rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rg, input logic [4:0] x,
                               input logic [4:0] y, input logic [4:0] z, input logic [4:0] id);
    cmd_valid = v;
    regen     = rg;
    cmd_x     = x;
    cmd_y     = y;
    cmd_z     = z;
    cmd_id    = id;
  endtask

  // Hand-written layer table: 1 at y<=2, 2 at y=3, 3 at y=4, air above.
  function automatic logic [4:0] expTerrain(input int y);
    if (y <= 2)      return 5'd1;
    else if (y == 3) return 5'd2;
    else if (y == 4) return 5'd3;
    else             return 5'd0;
  endfunction

  // Packed view {cmd_ready, init_done, busy, write_en, map_changed, cmd_rejected}.
  function automatic logic [5:0] flags();
    return {cmd_ready, init_done, busy, write_en, map_changed, cmd_rejected};
  endfunction

  // Checks n consecutive sweep writes starting at address 0; optionally the end cycle.
  task automatic sweepCheck(input int n, input bit checkEnd);
    int failsAtStart;
    logic [31:0] got;
    logic [31:0] exp;
    failsAtStart = failCount;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (failCount == failsAtStart) begin
        got = {10'd0, cmd_ready, busy, write_en, write_addr, write_data};
        exp = {10'd0, 1'b0, 1'b1, 1'b1, 15'(i), expTerrain(i / 1024)};
        checkOutput("sweep_write", got, exp);
      end
    end
    if (checkEnd) begin
      @(negedge clk);
      checkOutput("sweep_end_flags", 32'(flags()), 32'b110010);
    end
  endtask

  typedef struct {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [4:0]  z;
    logic [4:0]  id;
    logic [14:0] addr;
    logic        rej;
  } cmd_t;

  cmd_t b2b[4];

  initial begin
    b2b[0] = '{x: 5'd31, y: 5'd31, z: 5'd31, id: 5'd31, addr: 15'h7FFF, rej: 1'b0};
    b2b[1] = '{x: 5'd0,  y: 5'd1,  z: 5'd0,  id: 5'd2,  addr: 15'h0400, rej: 1'b0};
    b2b[2] = '{x: 5'd17, y: 5'd4,  z: 5'd12, id: 5'd7,  addr: 15'h1191, rej: 1'b0};
    b2b[3] = '{x: 5'd1,  y: 5'd0,  z: 5'd1,  id: 5'd9,  addr: 15'h0000, rej: 1'b1};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

    @(negedge clk);
    checkOutput("reset_flags", 32'(flags()), 32'b001000);
    checkOutput("reset_addr", 32'(write_addr), 32'h0);
    checkOutput("reset_data", 32'(write_data), 32'h0);

    // Partial sweep to cnt=1000, then reset must clear outputs asynchronously.
    @(negedge clk);
    rst_n = 1'b1;
    sweepCheck(1000, 1'b0);
    checkOutput("pre_abort_addr", 32'(write_addr), 32'd999);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_flags", 32'(flags()), 32'b001000);
    checkOutput("abort_addr", 32'(write_addr), 32'h0);
    checkOutput("abort_data", 32'(write_data), 32'h0);

    // Full sweep from address 0 after release.
    @(negedge clk);
    rst_n = 1'b1;
    sweepCheck(32768, 1'b1);
    @(negedge clk);
    checkOutput("idle_flags", 32'(flags()), 32'b110000);

    // Single edit: x=3 y=7 z=9 id=5 lands at 0x1D23 one clock after accept.
    applyStimulus(1'b1, 1'b0, 5'd3, 5'd7, 5'd9, 5'd5);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("edit_flags", 32'(flags()), 32'b011110);
    checkOutput("edit_addr", 32'(write_addr), 32'h1D23);
    checkOutput("edit_data", 32'(write_data), 32'd5);
    @(negedge clk);
    checkOutput("edit_after_flags", 32'(flags()), 32'b110000);

    // Floor edit is accepted but dropped.
    applyStimulus(1'b1, 1'b0, 5'd5, 5'd0, 5'd2, 5'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("floor_flags", 32'(flags()), 32'b011001);
    @(negedge clk);
    checkOutput("floor_after_flags", 32'(flags()), 32'b110000);

    // Back-to-back edits with cmd_valid held: one accept every second cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, b2b[k].x, b2b[k].y, b2b[k].z, b2b[k].id);
      @(negedge clk);
      if (k < 3) applyStimulus(1'b1, 1'b0, b2b[k+1].x, b2b[k+1].y, b2b[k+1].z, b2b[k+1].id);
      else       applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      if (b2b[k].rej) begin
        checkOutput($sformatf("b2b%0d_flags", k), 32'(flags()), 32'b011001);
      end else begin
        checkOutput($sformatf("b2b%0d_flags", k), 32'(flags()), 32'b011110);
        checkOutput($sformatf("b2b%0d_addr", k), 32'(write_addr), 32'(b2b[k].addr));
        checkOutput($sformatf("b2b%0d_data", k), 32'(write_data), 32'(b2b[k].id));
      end
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_gap_flags", k), 32'(flags()), 32'b110000);
    end

    // regen and cmd_valid together: sweep wins, edit stays pending until after it.
    applyStimulus(1'b1, 1'b1, 5'd6, 5'd10, 5'd2, 5'd4);
    @(negedge clk);
    checkOutput("regen_flags", 32'(flags()), 32'b001000);
    applyStimulus(1'b1, 1'b0, 5'd6, 5'd10, 5'd2, 5'd4);
    sweepCheck(32768, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("pending_flags", 32'(flags()), 32'b011110);
    checkOutput("pending_addr", 32'(write_addr), 32'h2846);
    checkOutput("pending_data", 32'(write_data), 32'd4);
    @(negedge clk);
    checkOutput("final_flags", 32'(flags()), 32'b110000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
